// File: rtl/sync_fifo_status_if.sv
// Pointer/status bundle between the FIFO address controllers and sync_fifo_status.
// The controller side (pointers and requests) is the master; the status block is the slave.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

interface sync_fifo_status_if #(
    parameter int ADDR_WIDTH = `ADDR_WIDTH
);
    logic [ADDR_WIDTH:0] wr_addr;
    logic [ADDR_WIDTH:0] rd_addr;
    logic                wr_valid;
    logic                rd_ready;
    logic                clr_stat;
    logic                rd_empty;
    logic                wr_full;
    logic [ADDR_WIDTH:0] fill_level;
    logic                almost_full;
    logic                almost_empty;
    logic [ADDR_WIDTH:0] high_water;
    logic                overflow;
    logic                underflow;

    modport master (
        output wr_addr, rd_addr, wr_valid, rd_ready, clr_stat,
        input  rd_empty, wr_full, fill_level, almost_full, almost_empty,
               high_water, overflow, underflow
    );

    modport slave (
        input  wr_addr, rd_addr, wr_valid, rd_ready, clr_stat,
        output rd_empty, wr_full, fill_level, almost_full, almost_empty,
               high_water, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_status.sv
// Synchronous FIFO pointer comparison: combinational empty/full, registered level and statistics.
// Define SYNC_FIFO_STICKY_ERR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif

module sync_fifo_status #(
    parameter int ADDR_WIDTH    = `ADDR_WIDTH,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input logic               clk,
    input logic               reset_n,
    sync_fifo_status_if.slave bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] level_next;
    logic [PW-1:0] fill_level_d, fill_level_q;
    logic          almost_full_d, almost_full_q;
    logic          almost_empty_d, almost_empty_q;
    logic [PW-1:0] high_water_d, high_water_q;

    // The extra pointer bit makes a lap difference distinguish full from empty.
    assign bus.rd_empty = (bus.wr_addr == bus.rd_addr);
    assign bus.wr_full  = (bus.wr_addr[ADDR_WIDTH] != bus.rd_addr[ADDR_WIDTH]) &&
                          (bus.wr_addr[ADDR_WIDTH-1:0] == bus.rd_addr[ADDR_WIDTH-1:0]);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        level_next     = bus.wr_addr - bus.rd_addr;
        fill_level_d   = level_next;
        almost_full_d  = (int'(level_next) >= AFULL_THRESH);
        almost_empty_d = (int'(level_next) <= AEMPTY_THRESH);
        high_water_d   = high_water_q;
        if (bus.clr_stat) begin
            high_water_d = level_next;
        end else if (level_next > high_water_q) begin
            high_water_d = level_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_level_q   <= '0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            high_water_q   <= '0;
        end else begin
            fill_level_q   <= fill_level_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            high_water_q   <= high_water_d;
        end
    end

    assign bus.fill_level   = fill_level_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.high_water   = high_water_q;

`ifdef SYNC_FIFO_STICKY_ERR_EN
    logic overflow_d, overflow_q;
    logic underflow_d, underflow_q;

    // Clear wins over a coincident set so software never misses the clear it asked for.
    always_comb begin
        overflow_d  = overflow_q  | (bus.wr_valid & bus.wr_full);
        underflow_d = underflow_q | (bus.rd_ready & bus.rd_empty);
        if (bus.clr_stat) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`else
    assign bus.overflow  = 1'b0;
    assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_status.sv
// Bench for sync_fifo_status: occupancy-level reference model checked every cycle, plus literal pins.
// Sticky-error expectations follow SYNC_FIFO_STICKY_ERR_EN as seen by this compilation.
`timescale 1ns/1ps

module tb_sync_fifo_status;
    localparam int AW    = 4;
    localparam int DEPTH = 2**AW;
    localparam int MODV  = 2*DEPTH;
`ifdef SYNC_FIFO_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    // Reference state: occupancy and statistics as plain integers.
    int m_fill = 0;
    int m_hw   = 0;
    bit m_af   = 1'b0;
    bit m_ae   = 1'b1;
    bit m_ov   = 1'b0;
    bit m_un   = 1'b0;

    sync_fifo_status_if #(.ADDR_WIDTH(AW)) bus ();

    sync_fifo_status #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int occupancy();
        return (int'(bus.wr_addr) - int'(bus.rd_addr) + MODV) % MODV;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_fill <= 0;
            m_hw   <= 0;
            m_af   <= 1'b0;
            m_ae   <= 1'b1;
            m_ov   <= 1'b0;
            m_un   <= 1'b0;
        end else begin
            int lvl;
            lvl = occupancy();
            m_fill <= lvl;
            m_af   <= (lvl >= DEPTH - 2);
            m_ae   <= (lvl <= 2);
            m_hw   <= bus.clr_stat ? lvl : ((lvl > m_hw) ? lvl : m_hw);
            if (STICKY) begin
                m_ov <= bus.clr_stat ? 1'b0 : (m_ov | (bus.wr_valid && lvl == DEPTH));
                m_un <= bus.clr_stat ? 1'b0 : (m_un | (bus.rd_ready && lvl == 0));
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd_empty",     bus.rd_empty,     occupancy() == 0);
            check("wr_full",      bus.wr_full,      occupancy() == DEPTH);
            check("fill_level",   bus.fill_level,   m_fill);
            check("almost_full",  bus.almost_full,  m_af);
            check("almost_empty", bus.almost_empty, m_ae);
            check("high_water",   bus.high_water,   m_hw);
            check("overflow",     bus.overflow,     m_ov);
            check("underflow",    bus.underflow,    m_un);
        end
    end

    // Inputs change 2ns after the rising edge, clear of both sampling points.
    task automatic step(input int wr, input int rd, input bit wv, input bit rr, input bit clr);
        @(posedge clk);
        #2;
        bus.wr_addr  = wr[AW:0];
        bus.rd_addr  = rd[AW:0];
        bus.wr_valid = wv;
        bus.rd_ready = rr;
        bus.clr_stat = clr;
    endtask

    initial begin
        int wr_p;
        int rd_p;
        bus.wr_addr  = '0;
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.clr_stat = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rd_empty",     bus.rd_empty,     1);
        check("rst_wr_full",      bus.wr_full,      0);
        check("rst_fill",         bus.fill_level,   0);
        check("rst_almost_empty", bus.almost_empty, 1);
        check("rst_almost_full",  bus.almost_full,  0);
        check("rst_high_water",   bus.high_water,   0);
        check("rst_overflow",     bus.overflow,     0);
        check("rst_underflow",    bus.underflow,    0);
        cmp_en = 1'b1;
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Fill from empty to full with the read pointer parked at 0.
        for (int i = 0; i <= DEPTH; i++) begin
            step(i, 0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            if (i == 14) begin
                check("fill_at_wr14",  bus.fill_level,  13);
                check("af_at_wr14",    bus.almost_full, 0);
            end
            if (i == 15) begin
                check("fill_at_wr15",  bus.fill_level,  14);
                check("af_after_wr14", bus.almost_full, 1);
            end
            if (i == 16) check("full_at_wr16", bus.wr_full, 1);
        end

        // Pointer wrap: 3 - 29 mod 32 = 6.
        step(3, 29, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("wrap_empty", bus.rd_empty, 0);
        check("wrap_full",  bus.wr_full,  0);
        step(3, 29, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("wrap_fill", bus.fill_level, 6);

        // Overflow set, hold, clear, and set coincident with clear.
        step(16, 0, 1'b1, 1'b0, 1'b0);
        step(16, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_set",  bus.overflow, STICKY);
        step(16, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_hold", bus.overflow, STICKY);
        step(16, 0, 1'b0, 1'b0, 1'b1);
        step(16, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_clr", bus.overflow, 0);
        step(16, 0, 1'b1, 1'b0, 1'b1);
        step(16, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("ovf_clr_wins", bus.overflow, 0);

        // High-water: clear at empty, rise to 10, drain, refill to 5.
        step(0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) step(i, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) step(10, i, 1'b0, 1'b0, 1'b0);
        for (int i = 11; i <= 15; i++) step(i, 10, 1'b0, 1'b0, 1'b0);
        step(15, 10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hw_retained", bus.high_water, 10);
        check("hw_fill5",    bus.fill_level, 5);
        step(15, 10, 1'b0, 1'b0, 1'b1);
        step(15, 10, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("hw_after_clr", bus.high_water, 5);

        // Mixed traffic with simultaneous reads/writes and stray requests at the limits.
        wr_p = 15;
        rd_p = 10;
        for (int i = 0; i < 60; i++) begin
            int lvl;
            bit do_wr;
            bit do_rd;
            lvl   = (wr_p - rd_p + MODV) % MODV;
            do_wr = (i % 7 != 3) && (lvl < DEPTH) && (i < 40);
            do_rd = (i % 3 == 0 || i >= 40) && (lvl > 0);
            if (do_wr) wr_p = (wr_p + 1) % MODV;
            if (do_rd) rd_p = (rd_p + 1) % MODV;
            step(wr_p, rd_p, (i % 5 == 0), (i % 4 == 1), (i == 30));
        end

        // Underflow, then an asynchronous reset between edges.
        step(7, 7, 1'b0, 1'b1, 1'b0);
        step(7, 7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("udf_set", bus.underflow, STICKY);
        #1 reset_n = 1'b0;
        #1;
        check("udf_async_clr", bus.underflow,    0);
        check("async_fill",    bus.fill_level,   0);
        check("async_ae",      bus.almost_empty, 1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) step(7, 7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_status.md
# sync_fifo_status

Pointer-comparison and status stage of the synchronous FIFO. It sits directly upstream of the read-address controller and beside the write-address controller. It takes both (ADDR_WIDTH+1)-bit pointers and produces the combinational `rd_empty` / `wr_full` flags those controllers gate on. It also produces a registered fill level, almost-full/almost-empty flags, a high-water mark and sticky overflow/underflow error flags.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (4): FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- `AFULL_THRESH`, default 2^ADDR_WIDTH-2: `almost_full` asserts when level ≥ this.
- `AEMPTY_THRESH`, default 2: `almost_empty` asserts when level ≤ this.

Ports:
- `clk`  in  1  system clock; all flops on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `wr_addr`  in  ADDR_WIDTH+1  write pointer from the write controller.
- `rd_addr`  in  ADDR_WIDTH+1  read pointer from the read controller.
- `wr_valid`  in  1  write request (pre-gating).
- `rd_ready`  in  1  read request (pre-gating).
- `clr_stat`  in  1  synchronous clear of high-water mark and sticky errors.
- `rd_empty`  out  1  FIFO empty (combinational).
- `wr_full`  out  1  FIFO full (combinational).
- `fill_level`  out  ADDR_WIDTH+1  registered occupancy, 0..2^ADDR_WIDTH.
- `almost_full`  out  1  registered.
- `almost_empty`  out  1  registered.
- `high_water`  out  ADDR_WIDTH+1  registered peak of `fill_level`.
- `overflow`  out  1  sticky: write attempted while full.
- `underflow`  out  1  sticky: read attempted while empty.

## Operation
- `rd_empty` = (`wr_addr` == `rd_addr`), full width.
- `wr_full` = MSBs differ and ADDR_WIDTH LSBs equal.
- Both flags are pure combinational; there is no register between pointers and flags. Controllers gate `rd_en`/`wr_en` with them in the same cycle.
- Next level = (`wr_addr` − `rd_addr`) modulo 2^(ADDR_WIDTH+1), ADDR_WIDTH+1 bits unsigned. Pointer wrap-around is therefore transparent; value range is 0..2^ADDR_WIDTH.
- `fill_level` register loads the next level every cycle.
- `almost_full` / `almost_empty` registers load (next level ≥ AFULL_THRESH) / (next level ≤ AEMPTY_THRESH) every cycle, so they stay consistent with `fill_level`.
- `high_water` loads max(`high_water`, next level) every cycle. Compare is unsigned at ADDR_WIDTH+1 bits.
- `overflow` sets on a clock edge where `wr_valid` & `wr_full`.
- `underflow` sets on a clock edge where `rd_ready` & `rd_empty`.
- Error flags hold until `clr_stat` or reset.
- `clr_stat` (priority over set and max update): `high_water` ← next level; `overflow`, `underflow` ← 0.
- A simultaneous set condition and `clr_stat` resolves to clear.
- Reset values: `fill_level` 0, `almost_full` 0, `almost_empty` 1, `high_water` 0, `overflow` 0, `underflow` 0.
- Flags during reset follow the input pointers, which controllers also reset to 0, giving `rd_empty` 1 and `wr_full` 0.
- Reset is legal mid-operation; all registers return to reset values immediately and asynchronously.

## Timing
- `rd_empty` / `wr_full`: 0-cycle latency from pointer change.
- `fill_level`, almost flags, `high_water`: 1-cycle latency. They reflect the pointers sampled at the previous edge.
- Sticky errors are visible the cycle after the offending edge.
- A simultaneous read and write leaves the level unchanged.
- No handshake of its own; the block never back-pressures.

## Configuration
- Macro `SYNC_FIFO_STICKY_ERR_EN`.
- Defined: `overflow` / `underflow` logic as above.
- Undefined: both outputs tied to constant 0, no flops inferred, `clr_stat` affects only `high_water`.
- All other behaviour is identical in both builds.

## Test plan
- Reset with pointers 0 → `rd_empty`=1, `wr_full`=0, `fill_level`=0, `almost_empty`=1, `high_water`=0, errors 0.
- ADDR_WIDTH=4: `wr_addr` steps 0→16 with `rd_addr`=0:
  - `fill_level` tracks the pointer one cycle later.
  - `almost_full` rises the cycle after `wr_addr`=14.
  - `wr_full`=1 combinationally at `wr_addr`=16.
- Wrap: `wr_addr`=3, `rd_addr`=29 → `fill_level`=6 next cycle, `rd_empty`=0, `wr_full`=0.
- Full (`wr_addr`=16, `rd_addr`=0) with `wr_valid`=1 for one edge → `overflow`=1 next cycle.
  - `overflow` holds after `wr_valid` drops.
  - `clr_stat` pulse → `overflow`=0.
  - Repeat in the same cycle as `clr_stat` → stays 0.
- Drain 10 entries then refill to 5 → `high_water`=10 retained. `clr_stat` → `high_water`=5.
- Empty with `rd_ready`=1, then `reset_n` pulsed low mid-cycle → `underflow` set, then asynchronously 0. Without the macro, `underflow` stays 0 throughout.
